state_msgtopoly: RTL and testbench

- Kyber decryption/re-encryption message decoder (poly_frommsg). Converts a 256-bit message into a 256-coefficient polynomial and writes it, one coefficient per accepted cycle, into the Mp polynomial RAM.
- Bit value 1 maps to coefficient ceil(Q/2) = 1665; bit value 0 maps to 0.
- Address k takes message bit iMsg[255-k], so this block is the exact inverse of the poly-to-message stage.

---
 rtl/state_msgtopoly.sv | 113 +++++++++++
 tb/tb_state_msgtopoly.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/state_msgtopoly.sv
// Kyber poly_frommsg: expands a 256-bit message into 256 coefficients (0 or ceil(Q/2))
// and streams them, MSB first, into the Mp polynomial RAM with a ready/enable handshake.
module state_msgtopoly #(
    parameter int unsigned KYBER_N    = 256,
    parameter int unsigned KYBER_Q    = 3329,
    parameter int unsigned data_Width = 12,
    parameter int unsigned Msg_Bytes  = 32,
    parameter int unsigned Byte_bits  = 8,
    parameter int unsigned i_Msg_Size = Byte_bits * Msg_Bytes
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [i_Msg_Size-1:0] iMsg,
    input  logic                  Msg_Poly_WReady,
    output logic                  Msg_Poly_WEn,
    output logic [7:0]            Msg_Poly_WAd,
    output logic [data_Width-1:0] Msg_Poly_WData,
    output logic                  Busy,
    output logic                  Function_done
);

    localparam logic [data_Width-1:0] OneCoeff = data_Width'((KYBER_Q + 1) >> 1);
    localparam logic [7:0]            LastAddr = 8'(KYBER_N - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e                  state_q, state_d;
    logic [i_Msg_Size-1:0]   msg_q, msg_d;
    logic                    wen_q, wen_d;
    logic [7:0]              wad_q, wad_d;
    logic [data_Width-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q   <= '0;
            wen_q   <= 1'b0;
            wad_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            msg_q   <= msg_d;
            wen_q   <= wen_d;
            wad_q   <= wad_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        wen_d   = wen_q;
        wad_d   = wad_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWrite;
                    msg_d   = iMsg;
                    wen_d   = 1'b1;
                    wad_d   = '0;
                    wdata_d = iMsg[i_Msg_Size-1] ? OneCoeff : '0;
                    busy_d  = 1'b1;
                end
            end
            StWrite: begin
                // Stalled writes (WReady=0) leave every register untouched.
                if (wen_q && Msg_Poly_WReady) begin
                    msg_d   = msg_q << 1;
                    wdata_d = msg_q[i_Msg_Size-2] ? OneCoeff : '0;
                    if (wad_q == LastAddr) begin
                        state_d = StDone;
                        wen_d   = 1'b0;
                        wad_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        wad_d = wad_q + 8'd1;
                    end
                end
            end
            StDone: begin
                // Busy stays up through the done pulse and falls together with it.
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Msg_Poly_WEn   = wen_q;
    assign Msg_Poly_WAd   = wad_q;
    assign Msg_Poly_WData = wdata_q;
    assign Busy           = busy_q;
    assign Function_done  = done_q;

endmodule

// File: tb/tb_state_msgtopoly.sv
// Self-checking bench for state_msgtopoly: table-driven runs, randomized runs against a
// bit-to-coefficient reference model, and a mid-run reset sequence.
module tb_state_msgtopoly;

    localparam int MaxCycles = 2000;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [255:0] iMsg;
    logic         Msg_Poly_WReady;
    logic         Msg_Poly_WEn;
    logic [7:0]   Msg_Poly_WAd;
    logic [11:0]  Msg_Poly_WData;
    logic         Busy;
    logic         Function_done;

    int errors = 0;
    int checks = 0;

    state_msgtopoly dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .iMsg           (iMsg),
        .Msg_Poly_WReady(Msg_Poly_WReady),
        .Msg_Poly_WEn   (Msg_Poly_WEn),
        .Msg_Poly_WAd   (Msg_Poly_WAd),
        .Msg_Poly_WData (Msg_Poly_WData),
        .Busy           (Busy),
        .Function_done  (Function_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] msg;
        int           mode;      // 0: ready always, 1: ready toggles 1,0,..., 2: random
        bit           poke;      // pulse enable with another message at address 100
        int           exp_done;  // expected Function_done cycle, 0 = derive from stalls
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: coefficient k carries message bit 255-k, 1 -> ceil(3329/2), 0 -> 0.
    function automatic int model_coeff(input logic [255:0] msg, input int addr);
        return msg[255 - addr] ? (3329 + 1) / 2 : 0;
    endfunction

    task automatic run_msg(input logic [255:0] msg, input int mode, input bit poke,
                           input int exp_done);
        int  cyc;
        int  exp_addr;
        int  stalls;
        bit  done;
        bit  rdy;
        bit  poked;
        cyc      = 1;
        exp_addr = 0;
        stalls   = 0;
        done     = 1'b0;
        poked    = 1'b0;
        @(negedge clk);
        iMsg            = msg;
        enable          = 1'b1;
        Msg_Poly_WReady = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        iMsg   = ~msg;
        while (!done && cyc < MaxCycles) begin
            if (Function_done) begin
                done = 1'b1;
                check("done_cycle", cyc, (exp_done != 0) ? exp_done : 256 + stalls + 1);
                check("xfers_at_done", exp_addr, 256);
                check("busy_in_done", Busy, 1);
                check("wen_in_done", Msg_Poly_WEn, 0);
                check("wad_in_done", Msg_Poly_WAd, 0);
            end else begin
                check("busy", Busy, 1);
                check("wen", Msg_Poly_WEn, 1);
                check("wad", Msg_Poly_WAd, exp_addr);
                check("wdata", Msg_Poly_WData, model_coeff(msg, exp_addr & 255));
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 2) == 1;
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                if (poke && !poked && exp_addr == 100) begin
                    enable = 1'b1;
                    iMsg   = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
                    poked  = 1'b1;
                end else begin
                    enable = 1'b0;
                end
                if (rdy) exp_addr++;
                else stalls++;
                Msg_Poly_WReady = rdy;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) check("done_timeout", 0, 1);
        // enable during DONE must be neither taken nor queued.
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        check("done_pulse_width", Function_done, 0);
        check("busy_after_done", Busy, 0);
        check("wen_after_done", Msg_Poly_WEn, 0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [255:0] ends;
        logic [255:0] rnd;
        int           wait_cyc;
        ends = '0;
        ends[255] = 1'b1;
        ends[0]   = 1'b1;
        vecs[0] = '{msg: '0,                      mode: 0, poke: 1'b0, exp_done: 257};
        vecs[1] = '{msg: '1,                      mode: 0, poke: 1'b0, exp_done: 257};
        vecs[2] = '{msg: ends,                    mode: 0, poke: 1'b0, exp_done: 257};
        vecs[3] = '{msg: ends,                    mode: 1, poke: 1'b0, exp_done: 512};
        vecs[4] = '{msg: {8{32'hA5C3_0F96}},      mode: 0, poke: 1'b1, exp_done: 257};

        rst_n           = 1'b0;
        enable          = 1'b0;
        iMsg            = '0;
        Msg_Poly_WReady = 1'b0;
        #1;
        check("rst_wen", Msg_Poly_WEn, 0);
        check("rst_wad", Msg_Poly_WAd, 0);
        check("rst_wdata", Msg_Poly_WData, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Function_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_msg(vecs[i].msg, vecs[i].mode, vecs[i].poke, vecs[i].exp_done);
        end

        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            run_msg(rnd, 2, 1'b0, 0);
        end

        // Reset in the middle of a run, then a clean restart.
        @(negedge clk);
        iMsg            = {8{32'h1234_5678}};
        enable          = 1'b1;
        Msg_Poly_WReady = 1'b1;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        wait_cyc = 0;
        while (Msg_Poly_WAd != 8'd100 && wait_cyc < 400) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        check("reach_addr100", Msg_Poly_WAd, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wen", Msg_Poly_WEn, 0);
        check("midrst_wad", Msg_Poly_WAd, 0);
        check("midrst_wdata", Msg_Poly_WData, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Function_done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_hold_done", Function_done, 0);
            check("midrst_hold_busy", Busy, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_done", Function_done, 0);
        check("post_rst_wen", Msg_Poly_WEn, 0);
        run_msg('1, 0, 1'b0, 257);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
